// File: rtl/std_skid_buffer.sv
// Two-entry valid/ready skid buffer: main register plus a skid register, with registered s_ready/m_valid.
// One cycle of latency and full throughput; under back-pressure it holds two entries, then deasserts s_ready.
module std_skid_buffer #(
  parameter int                    DATA_WIDTH       = 32,
  parameter logic [DATA_WIDTH-1:0] DATA_RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic                  flush,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic                  main_load;
  logic                  main_sel_skid;
  logic                  skid_load;
  logic [DATA_WIDTH-1:0] main_q;
  logic [DATA_WIDTH-1:0] skid_q;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    main_load     = 1'b0;
    main_sel_skid = 1'b0;
    skid_load     = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (s_valid) begin
            state_nxt = BUSY;
            main_load = 1'b1;
          end
        end
        BUSY: begin
          if (s_valid && m_ready) begin
            main_load = 1'b1;
          end else if (s_valid) begin
            state_nxt = FULL;
            skid_load = 1'b1;
          end else if (m_ready) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          // s_ready is low here, so the only move is draining skid into main.
          if (m_ready) begin
            state_nxt     = BUSY;
            main_load     = 1'b1;
            main_sel_skid = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      main_q <= DATA_RESET_VALUE;
      skid_q <= DATA_RESET_VALUE;
    end else begin
      if (main_load) begin
        main_q <= main_sel_skid ? skid_q : s_data;
      end
      if (skid_load) begin
        skid_q <= s_data;
      end
    end
  end

  assign m_valid = (state != EMPTY);
  assign s_ready = (state != FULL);
  assign m_data  = main_q;

endmodule
